// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults, FSM state type and pixel-to-fixed conversion for the image source
package conv_pkg;
    localparam int N_DEF = 100;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int Q_DEF = 10;
    localparam int ADDR_W = $clog2(N_DEF * N_DEF);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

    // Any nonzero pixel saturates when the shifted pixel could not fit the output width
    function automatic logic [63:0] pix_to_fixed(input logic [7:0] pix, input int q, input int dw);
        logic [63:0] ones;
        ones = (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
        return (8 + q > dw) ? ((pix != 8'd0) ? ones : 64'd0) : ({56'd0, pix} << q);
    endfunction
endpackage

// File: rtl/conv_img_ram.sv
// conv_img_ram: 8-bit image store with one write port and one registered read port
module conv_img_ram #(
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/conv_img_source.sv
// conv_img_source: streams a stored N*N 8-bit image as fixed-point words over a valid/ready link
module conv_img_source
    import conv_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int Q = Q_DEF,
    localparam int AW = $clog2(N * N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [7:0]            wr_pixel_i,
    input  logic                  start_i,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  running_o,
    output logic                  done_o
);
    localparam logic [AW:0] NN = (AW + 1)'(N * N);

    state_t                state;
    logic [AW:0]           rd_addr;
    logic                  ram_vld, valid_q, we, rd_en, load, last;
    logic [7:0]            ram_data;
    logic [DATA_WIDTH-1:0] data_q;

    assign we = wr_en_i && state == IDLE && {1'b0, wr_addr_i} < NN;
    // ram_vld marks a fetched pixel waiting in the RAM output; it moves out only when the output slot frees
    assign load = state == STREAM && ram_vld && (!valid_q || ready_i);
    assign rd_en = state == PRIME || (load && rd_addr < NN);
    assign last = rd_addr == NN && !ram_vld;

    conv_img_ram #(.DEPTH(N * N), .AW(AW)) u_ram (
        .clk(clk),
        .wr_en(we),
        .wr_addr(wr_addr_i),
        .wr_data(wr_pixel_i),
        .rd_en(rd_en),
        .rd_addr(rd_addr[AW-1:0]),
        .rd_data(ram_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rd_addr <= '0;
            ram_vld <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state <= (state == IDLE && start_i) ? PRIME :
                     (state == PRIME) ? STREAM :
                     (state == STREAM && valid_q && ready_i && last) ? DONE :
                     (state == DONE) ? IDLE : state;
            rd_addr <= (state == IDLE) ? '0 : rd_en ? rd_addr + 1'b1 : rd_addr;
            ram_vld <= rd_en || (ram_vld && !load);
            valid_q <= load || (valid_q && !ready_i);
            if (load) data_q <= DATA_WIDTH'(pix_to_fixed(ram_data, Q, DATA_WIDTH));
        end
    end

    assign data_o = valid_q ? data_q : '0;
    assign valid_o = valid_q;
    assign running_o = state != IDLE;
    assign done_o = state == DONE;
endmodule

// File: tb/tb_conv_img_source.sv
// tb_conv_img_source: scoreboard bench for the image source, plus a saturating instance
module tb_conv_img_source;
    logic        clk = 1'b0, rst = 1'b0;
    logic        wr_en = 1'b0, start = 1'b0, ready = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [7:0]  wr_pixel = 8'd0;
    logic [31:0] data;
    logic        valid, running, done;
    logic        s_wr_en = 1'b0, s_start = 1'b0, s_ready = 1'b1;
    logic [3:0]  s_wr_addr = 4'd0;
    logic [7:0]  s_wr_pixel = 8'd0;
    logic [31:0] s_data;
    logic        s_valid, s_running, s_done;

    always #5 clk = ~clk;

    conv_img_source #(.N(4), .DATA_WIDTH(32), .Q(10)) dut (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_pixel_i(wr_pixel),
        .start_i(start), .ready_i(ready), .data_o(data), .valid_o(valid),
        .running_o(running), .done_o(done)
    );

    conv_img_source #(.N(4), .DATA_WIDTH(32), .Q(26)) sat (
        .clk(clk), .rst(rst), .wr_en_i(s_wr_en), .wr_addr_i(s_wr_addr), .wr_pixel_i(s_wr_pixel),
        .start_i(s_start), .ready_i(s_ready), .data_o(s_data), .valid_o(s_valid),
        .running_o(s_running), .done_o(s_done)
    );

    int          n_cmp = 0, n_err = 0, hs_cnt = 0, done_cnt = 0;
    logic [31:0] exp_q[$];
    logic        pv = 1'b0, pr = 1'b0;
    logic [31:0] pd = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshakes are judged on the falling edge, before the rising edge that commits them
    always @(negedge clk) begin
        if (!rst) pv = 1'b0;
        else begin
            if (valid && ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL extra_word: observed %0h expected no word", data);
                end else chk("word", data, exp_q.pop_front());
            end
            if (!valid) chk("data_zero_idle", data, 32'd0);
            if (pv && !pr) begin
                chk("stall_valid", valid, 1);
                chk("stall_data", data, pd);
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last", hs_cnt, 16);
            end
            pv = valid;
            pr = ready;
            pd = data;
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] p);
        wr_en = 1'b1;
        wr_addr = a;
        wr_pixel = p;
        tick();
        wr_en = 1'b0;
    endtask

    // mode 0: ready high, 1: ready toggles, 2: 5-cycle stall on the last word,
    // 3: extra start and write mid-frame, 4: reset after 7 handshakes
    task automatic run_frame(input int mode, input logic [31:0] first, input bit wr0);
        bit stalled = 1'b0;
        exp_q.delete();
        hs_cnt = 0;
        done_cnt = 0;
        exp_q.push_back(first);
        for (int k = 1; k < 16; k++) exp_q.push_back(32'(k) << 10);
        wr_en = wr0;
        wr_addr = 4'd0;
        wr_pixel = 8'd200;
        start = 1'b1;
        ready = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        chk("prime_running", running, 1);
        chk("prime_valid", valid, 0);
        tick();
        chk("valid_lat1", valid, 0);
        tick();
        chk("valid_lat2", valid, 1);
        for (int c = 0; c < 300; c++) begin
            if (done) break;
            if (mode == 4 && hs_cnt >= 7) begin
                #2 rst = 1'b0;
                #1;
                chk("abort_valid", valid, 0);
                chk("abort_data", data, 0);
                chk("abort_running", running, 0);
                chk("abort_done", done, 0);
                return;
            end
            ready = (mode == 1) ? (c % 2 == 0) : 1'b1;
            if (mode == 3) begin
                start = (c == 3);
                wr_en = (c == 3);
                wr_addr = 4'd1;
                wr_pixel = 8'd99;
            end
            if (mode == 2 && !stalled && valid && data == 32'd15360) begin
                stalled = 1'b1;
                ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("hold_valid", valid, 1);
                    chk("hold_data", data, 32'd15360);
                    chk("hold_no_done", done, 0);
                end
                ready = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        wr_en = 1'b0;
        chk("done_reached", done, 1);
        chk("done_running", running, 1);
        tick();
        chk("done_count", done_cnt, 1);
        chk("handshakes", hs_cnt, 16);
        chk("queue_empty", exp_q.size(), 0);
        chk("idle_running", running, 0);
        chk("idle_valid", valid, 0);
        chk("idle_done", done, 0);
        if (mode == 2) chk("stall_seen", stalled, 1);
        tick();
        chk("no_restart", running, 0);
    endtask

    initial begin
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("release_idle", running, 0);
        for (int k = 0; k < 16; k++) wr(4'(k), 8'(k));
        run_frame(0, 32'd0, 1'b0);
        run_frame(1, 32'd0, 1'b0);
        run_frame(2, 32'd0, 1'b0);
        run_frame(3, 32'd204800, 1'b1);
        run_frame(0, 32'd204800, 1'b0);
        run_frame(4, 32'd204800, 1'b0);
        tick();
        chk("in_rst_valid", valid, 0);
        chk("in_rst_running", running, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_valid", valid, 0);
        chk("post_rst_running", running, 0);
        run_frame(0, 32'd204800, 1'b0);
        s_wr_en = 1'b1;
        s_wr_addr = 4'd0;
        s_wr_pixel = 8'd255;
        tick();
        s_wr_addr = 4'd1;
        s_wr_pixel = 8'd0;
        tick();
        s_wr_en = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tick();
        tick();
        chk("sat_valid", s_valid, 1);
        chk("sat_ones", s_data, 32'hFFFF_FFFF);
        tick();
        chk("sat_zero", s_data, 32'd0);
        chk("sat_running", s_running, 1);
        chk("sat_no_done", s_done, 0);
        repeat (20) tick();
        chk("sat_idle", s_running, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
